// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD moving-picture controller.
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W       = 18;
  localparam int COORD_W      = 10;
  localparam int CMP_W        = COORD_W + 1;
  localparam int STEP_W       = 3;
  localparam int SPD_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MOVE = 2'd2,
    HOLD = 2'd3
  } mov_state_e;

endpackage

// File: rtl/lcd_axis_bounce.sv
// One axis of the bouncing origin: advance by step, clamp into [0, max] and
// reverse direction on contact. Purely combinational; the caller registers it.
module lcd_axis_bounce
  import lcd_pkg::*;
(
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_i,
  input  logic [STEP_W-1:0]  step_i,
  input  logic [COORD_W-1:0] max_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] pos_o,
  output logic               dir_o,
  output logic               hit_o
);

  logic [CMP_W-1:0] pos_w;
  logic [CMP_W-1:0] step_w;
  logic [CMP_W-1:0] max_w;
  logic [CMP_W-1:0] sum_w;

  // One extra bit so pos+step near the upper bound cannot wrap.
  assign pos_w  = CMP_W'(pos_i);
  assign step_w = CMP_W'(step_i);
  assign max_w  = CMP_W'(max_i);
  assign sum_w  = pos_w + step_w;

  always_comb begin
    pos_o = pos_i;
    dir_o = dir_i;
    hit_o = 1'b0;
    if (en_i && (step_i != '0)) begin
      if (dir_i) begin
        if (sum_w >= max_w) begin
          pos_o = max_i;
          dir_o = 1'b0;
          hit_o = 1'b1;
        end else begin
          pos_o = sum_w[COORD_W-1:0];
        end
      end else begin
        if (pos_w <= step_w) begin
          pos_o = '0;
          dir_o = 1'b1;
          hit_o = 1'b1;
        end else begin
          pos_o = pos_i - COORD_W'(step_i);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_mov_ctrl.sv
// Bouncing-picture controller: frame-paced origin motion plus the per-pixel
// window flag and picture ROM address for the current scan position.
module lcd_mov_ctrl
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIC_SIZE = 400,
  parameter int INIT_X   = 1,
  parameter int INIT_Y   = 1
) (
  input  logic               clk_in,
  input  logic               sys_rst,
  input  logic               frame_start,
  input  logic               run,
  input  logic [SPD_W-1:0]   speed_div,
  input  logic [STEP_W-1:0]  step,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] pic_xp,
  output logic [COORD_W-1:0] pic_yp,
  output logic               h_dir,
  output logic               v_dir,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               in_win,
  output logic               hit_x,
  output logic               hit_y
);

  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_ACTIVE - PIC_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - PIC_SIZE);
  localparam logic [CMP_W-1:0]   PIC_W     = CMP_W'(PIC_SIZE);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(PIC_SIZE * PIC_SIZE - 1);
  localparam logic [1:0][COORD_W-1:0] INIT_POS = {COORD_W'(INIT_Y), COORD_W'(INIT_X)};
  localparam logic [1:0][COORD_W-1:0] MAX_POS  = {Y_MAX, X_MAX};

  mov_state_e state_q, state_d;
  logic [SPD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic cnt_due, cnt_inc, cnt_clr, move_en;

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  logic [1:0][COORD_W-1:0] pos_q, pos_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] hit_q, hit_d;

  logic [CMP_W-1:0] px_w, py_w, xp_w, yp_w;
  logic win_d, in_win_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  assign cnt_due = (frame_cnt_q >= speed_div);

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = WAIT;
      WAIT: begin
        if (!run) begin
          state_d = HOLD;
        end else if (frame_start && cnt_due) begin
          state_d = MOVE;
        end
      end
      MOVE:    state_d = WAIT;
      HOLD:    if (run) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    move_en = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      WAIT: cnt_inc = run && frame_start && !cnt_due;
      MOVE: begin
        move_en = 1'b1;
        cnt_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (cnt_clr) begin
      frame_cnt_d = '0;
    end else if (cnt_inc) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    lcd_axis_bounce u_axis (
      .pos_i (pos_q[gi]),
      .dir_i (dir_q[gi]),
      .step_i(step),
      .max_i (MAX_POS[gi]),
      .en_i  (move_en),
      .pos_o (pos_d[gi]),
      .dir_o (dir_d[gi]),
      .hit_o (hit_d[gi])
    );
  end

  // Window is judged against the origin in force now, not the one about to be written.
  assign px_w  = CMP_W'(pix_x);
  assign py_w  = CMP_W'(pix_y);
  assign xp_w  = CMP_W'(pos_q[0]);
  assign yp_w  = CMP_W'(pos_q[1]);
  assign win_d = (px_w >= xp_w) && (px_w < xp_w + PIC_W) &&
                 (py_w >= yp_w) && (py_w < yp_w + PIC_W);

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (frame_start) begin
      rd_addr_d = '0;
    end else if (win_d && (rd_addr_q < ADDR_LAST)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      frame_cnt_q <= '0;
      pos_q       <= INIT_POS;
      dir_q       <= 2'b11;
      hit_q       <= 2'b00;
      in_win_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      in_win_q    <= win_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign pic_xp  = pos_q[0];
  assign pic_yp  = pos_q[1];
  assign h_dir   = dir_q[0];
  assign v_dir   = dir_q[1];
  assign hit_x   = hit_q[0];
  assign hit_y   = hit_q[1];
  assign in_win  = in_win_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_lcd_mov_ctrl.sv
// Self-checking bench for lcd_mov_ctrl: window vectors, directed motion
// sequences, a bounce corner on a narrow instance, a full scan on a small
// instance, and randomized frames against a frame-level reference model.
module tb_lcd_mov_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic       sys_rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       run = 1'b0;
  logic [3:0] speed_div = 4'd0;
  logic [2:0] step = 3'd0;
  logic [9:0] pix_x = 10'd799;
  logic [9:0] pix_y = 10'd479;
  logic [9:0] pic_xp, pic_yp;
  logic       h_dir, v_dir, in_win, hit_x, hit_y;
  logic [17:0] rd_addr;

  lcd_mov_ctrl dut (
    .clk_in(clk), .sys_rst(sys_rst), .frame_start(frame_start), .run(run),
    .speed_div(speed_div), .step(step), .pix_x(pix_x), .pix_y(pix_y),
    .pic_xp(pic_xp), .pic_yp(pic_yp), .h_dir(h_dir), .v_dir(v_dir),
    .rd_addr(rd_addr), .in_win(in_win), .hit_x(hit_x), .hit_y(hit_y)
  );

  // narrow instance: X_MAX=2, Y_MAX=80, origin (1,75)
  logic       b_fs = 1'b0;
  logic       b_run = 1'b0;
  logic [2:0] b_step = 3'd0;
  logic [9:0] b_xp, b_yp;
  logic       b_hd, b_vd, b_win, b_hx, b_hy;
  logic [17:0] b_rd;

  lcd_mov_ctrl #(.H_ACTIVE(402), .V_ACTIVE(480), .PIC_SIZE(400), .INIT_X(1), .INIT_Y(75)) dut_b (
    .clk_in(clk), .sys_rst(sys_rst), .frame_start(b_fs), .run(b_run),
    .speed_div(4'd0), .step(b_step), .pix_x(10'd0), .pix_y(10'd0),
    .pic_xp(b_xp), .pic_yp(b_yp), .h_dir(b_hd), .v_dir(b_vd),
    .rd_addr(b_rd), .in_win(b_win), .hit_x(b_hx), .hit_y(b_hy)
  );

  // small instance for a complete scan: 40x24 screen, 20x20 picture at (0,0)
  logic       s_fs = 1'b0;
  logic [9:0] s_px = 10'd39;
  logic [9:0] s_py = 10'd23;
  logic [9:0] s_xp, s_yp;
  logic       s_hd, s_vd, s_win, s_hx, s_hy;
  logic [17:0] s_rd;

  lcd_mov_ctrl #(.H_ACTIVE(40), .V_ACTIVE(24), .PIC_SIZE(20), .INIT_X(0), .INIT_Y(0)) dut_s (
    .clk_in(clk), .sys_rst(sys_rst), .frame_start(s_fs), .run(1'b0),
    .speed_div(4'd0), .step(3'd0), .pix_x(s_px), .pix_y(s_py),
    .pic_xp(s_xp), .pic_yp(s_yp), .h_dir(s_hd), .v_dir(s_vd),
    .rd_addr(s_rd), .in_win(s_win), .hit_x(s_hx), .hit_y(s_hy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: origin state plus "armed" flag, frame tally and a pending move.
  int e_xp, e_yp, e_hd, e_vd, e_hx, e_hy, e_win, e_rd;
  bit m_active, m_pending;
  int m_cnt;

  task automatic bounce(inout int pos, inout int dir, output int hit, input int stp, input int mx);
    hit = 0;
    if (stp == 0) return;
    if (dir == 1) begin
      if (pos + stp >= mx) begin pos = mx; dir = 0; hit = 1; end
      else pos = pos + stp;
    end else begin
      if (pos <= stp) begin pos = 0; dir = 1; hit = 1; end
      else pos = pos - stp;
    end
  endtask

  task automatic model_clock();
    int xo, yo, w, hx, hy;
    xo = e_xp;
    yo = e_yp;
    e_hx = 0;
    e_hy = 0;
    if (sys_rst) begin
      e_xp = 1; e_yp = 1; e_hd = 1; e_vd = 1; e_win = 0; e_rd = 0;
      m_active = 0; m_pending = 0; m_cnt = 0;
      return;
    end
    w = (int'(pix_x) >= xo && int'(pix_x) < xo + 400 &&
         int'(pix_y) >= yo && int'(pix_y) < yo + 400) ? 1 : 0;
    e_win = w;
    if (frame_start) e_rd = 0;
    else if (w == 1 && e_rd < 159999) e_rd++;
    if (m_pending) begin
      bounce(e_xp, e_hd, hx, int'(step), 400);
      bounce(e_yp, e_vd, hy, int'(step), 80);
      e_hx = hx;
      e_hy = hy;
      m_pending = 0;
      m_active = 1;
      m_cnt = 0;
    end else if (!m_active) begin
      m_active = run;
    end else if (!run) begin
      m_active = 0;
    end else if (frame_start) begin
      if (m_cnt >= int'(speed_div)) m_pending = 1;
      else m_cnt++;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    chk("m_xp", 32'(pic_xp), e_xp);
    chk("m_yp", 32'(pic_yp), e_yp);
    chk("m_hdir", 32'(h_dir), e_hd);
    chk("m_vdir", 32'(v_dir), e_vd);
    chk("m_hitx", 32'(hit_x), e_hx);
    chk("m_hity", 32'(hit_y), e_hy);
    chk("m_inwin", 32'(in_win), e_win);
    chk("m_rdaddr", 32'(rd_addr), e_rd);
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
    logic       win;
    int         rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s_cnt;
    vecs[0]  = '{10'd0,   10'd0,   1'b1, 1'b0, 0};
    vecs[1]  = '{10'd1,   10'd1,   1'b0, 1'b1, 1};
    vecs[2]  = '{10'd400, 10'd400, 1'b0, 1'b1, 2};
    vecs[3]  = '{10'd401, 10'd1,   1'b0, 1'b0, 2};
    vecs[4]  = '{10'd400, 10'd1,   1'b0, 1'b1, 3};
    vecs[5]  = '{10'd1,   10'd401, 1'b0, 1'b0, 3};
    vecs[6]  = '{10'd1,   10'd400, 1'b0, 1'b1, 4};
    vecs[7]  = '{10'd0,   10'd5,   1'b0, 1'b0, 4};
    vecs[8]  = '{10'd799, 10'd479, 1'b0, 1'b0, 4};
    vecs[9]  = '{10'd200, 10'd300, 1'b1, 1'b1, 0};
    vecs[10] = '{10'd200, 10'd300, 1'b0, 1'b1, 1};
    vecs[11] = '{10'd401, 10'd401, 1'b0, 1'b0, 1};

    // reset values
    sys_rst = 1'b1;
    tick();
    tick();
    chk("rst_xp", 32'(pic_xp), 1);
    chk("rst_yp", 32'(pic_yp), 1);
    chk("rst_dirs", {30'd0, h_dir, v_dir}, 3);
    chk("rst_hits", {30'd0, hit_x, hit_y}, 0);
    chk("rst_inwin", 32'(in_win), 0);
    chk("rst_rd", 32'(rd_addr), 0);
    sys_rst = 1'b0;

    // window compare and address counter against origin (1,1)
    for (int i = 0; i < 12; i++) begin
      pix_x = vecs[i].px;
      pix_y = vecs[i].py;
      frame_start = vecs[i].fs;
      tick();
      chk($sformatf("vec%0d_win", i), 32'(in_win), 32'(vecs[i].win));
      chk($sformatf("vec%0d_rd", i), 32'(rd_addr), vecs[i].rd);
    end
    frame_start = 1'b0;
    pix_x = 10'd799;
    pix_y = 10'd479;

    // three single-pixel moves from (1,1)
    run = 1'b1; speed_div = 4'd0; step = 3'd1;
    tick();
    repeat (3) fs_pulse();
    chk("seq1_xp", 32'(pic_xp), 4);
    chk("seq1_yp", 32'(pic_yp), 4);
    chk("seq1_dirs", {30'd0, h_dir, v_dir}, 3);

    // vertical bounce at Y_MAX
    step = 3'd7;
    repeat (10) fs_pulse();
    step = 3'd4;
    fs_pulse();
    chk("seq2_yp78", 32'(pic_yp), 78);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("seq2_hity_on", 32'(hit_y), 1);
    chk("seq2_yp80", 32'(pic_yp), 80);
    chk("seq2_vdir", 32'(v_dir), 0);
    chk("seq2_hitx_off", 32'(hit_x), 0);
    tick();
    chk("seq2_hity_off", 32'(hit_y), 0);
    tick();
    fs_pulse();
    chk("seq2_yp76", 32'(pic_yp), 76);
    chk("seq2_xp86", 32'(pic_xp), 86);

    // frame divider: 6 frames at speed_div=2 give 2 moves
    speed_div = 4'd2; step = 3'd1;
    repeat (6) fs_pulse();
    chk("seq3_xp", 32'(pic_xp), 88);
    chk("seq3_yp", 32'(pic_yp), 74);
    repeat (2) fs_pulse();
    frame_start = 1'b1; run = 1'b0;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    chk("seq3_hold_xp", 32'(pic_xp), 88);
    chk("seq3_hold_yp", 32'(pic_yp), 74);
    run = 1'b1;
    tick();

    // reset landing on the MOVE cycle
    speed_div = 4'd0; step = 3'd5;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("seq4_xp", 32'(pic_xp), 1);
    chk("seq4_yp", 32'(pic_yp), 1);
    chk("seq4_dirs", {30'd0, h_dir, v_dir}, 3);
    chk("seq4_hits", {30'd0, hit_x, hit_y}, 0);
    chk("seq4_rd", 32'(rd_addr), 0);
    speed_div = 4'd1; step = 3'd2;
    tick();
    tick();
    fs_pulse();
    chk("seq4_first_fs", 32'(pic_xp), 1);
    fs_pulse();
    chk("seq4_second_fs", 32'(pic_xp), 3);

    // both axes bounce on the same move (narrow instance)
    b_run = 1'b1; b_step = 3'd1;
    tick();
    b_fs = 1'b1; tick(); b_fs = 1'b0; tick();
    chk("b1_xp", 32'(b_xp), 2);
    chk("b1_hdir", 32'(b_hd), 0);
    chk("b1_hitx", 32'(b_hx), 1);
    chk("b1_yp", 32'(b_yp), 76);
    tick(); tick();
    b_fs = 1'b1; tick(); b_fs = 1'b0; tick();
    chk("b2_xp", 32'(b_xp), 1);
    chk("b2_yp", 32'(b_yp), 77);
    chk("b2_dirs", {30'd0, b_hd, b_vd}, 1);
    tick(); tick();
    b_step = 3'd3;
    b_fs = 1'b1; tick(); b_fs = 1'b0; tick();
    chk("b3_xp", 32'(b_xp), 0);
    chk("b3_yp", 32'(b_yp), 80);
    chk("b3_dirs", {30'd0, b_hd, b_vd}, 2);
    chk("b3_hits", {30'd0, b_hx, b_hy}, 3);
    tick();
    chk("b3_hits_off", {30'd0, b_hx, b_hy}, 0);
    chk("b_inwin", 32'(b_win), 0);
    chk("b_rd", 32'(b_rd), 0);
    b_run = 1'b0;

    // full 40x24 scan on the small instance
    s_px = 10'd39; s_py = 10'd23; s_fs = 1'b1;
    tick();
    s_fs = 1'b0;
    s_cnt = 0;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 40; x++) begin
        s_px = 10'(x);
        s_py = 10'(y);
        tick();
        if (s_win === 1'b1) s_cnt++;
      end
    end
    chk("scan_inwin_cycles", s_cnt, 400);
    chk("scan_rd_end", 32'(s_rd), 399);
    s_px = 10'd5; s_py = 10'd5;
    repeat (3) tick();
    chk("scan_rd_sat", 32'(s_rd), 399);
    chk("scan_inwin_hold", 32'(s_win), 1);
    s_px = 10'd30; s_fs = 1'b1;
    tick();
    s_fs = 1'b0;
    chk("scan_rd_clear", 32'(s_rd), 0);
    chk("scan_static", {s_xp, s_yp, 8'd0, s_hd, s_vd, s_hx, s_hy}, 32'h0000_000C);

    // randomized frames against the model
    for (int it = 0; it < 400; it++) begin
      int gap;
      run = ($urandom_range(0, 9) != 0);
      speed_div = 4'($urandom_range(0, 3));
      step = 3'($urandom_range(0, 7));
      sys_rst = ($urandom_range(0, 99) == 0);
      pix_x = 10'($urandom_range(0, 799));
      pix_y = 10'($urandom_range(0, 479));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      sys_rst = 1'b0;
      gap = $urandom_range(2, 5);
      for (int g = 0; g < gap; g++) begin
        pix_x = 10'($urandom_range(0, 799));
        pix_y = 10'($urandom_range(0, 479));
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
